// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared layer types: default word width, read-out state encoding, signed compare
package nn_pkg;

  localparam int NN_WIDTH = 21;
  localparam int NN_CMP_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } rd_state_t;

  // Callers sign-extend their operands to NN_CMP_W so one helper serves every word width.
  function automatic logic signed_gt(input logic signed [NN_CMP_W-1:0] a,
                                     input logic signed [NN_CMP_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - running signed maximum and its index over a sampled sequence
module argmax_tracker
  import nn_pkg::*;
#(
  parameter int WIDTH = NN_WIDTH,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_first,
  input  logic             en,
  input  logic [WIDTH-1:0] val,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] max_val,
  output logic [IDX_W-1:0] max_idx
);

  logic [NN_CMP_W-1:0] val_ext;
  logic [NN_CMP_W-1:0] max_ext;
  logic                take;

  assign val_ext = {{(NN_CMP_W-WIDTH){val[WIDTH-1]}}, val};
  assign max_ext = {{(NN_CMP_W-WIDTH){max_val[WIDTH-1]}}, max_val};

  // Strictly greater only, so on a tie the earlier (lower) index is kept.
  assign take = clr_first || signed_gt(val_ext, max_ext);

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (en && take) begin
      max_val <= val;
      max_idx <= idx;
    end
  end

endmodule

// File: rtl/neuron_output_reader.sv
// rtl/neuron_output_reader.sv - walks the result-register bank, streams each word, reports argmax
module neuron_output_reader
  import nn_pkg::*;
#(
  parameter int N_NEURONS = 10,
  parameter int WIDTH     = NN_WIDTH,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [IDX_W-1:0] max_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      rd_addr  <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx     <= '0;
            rd_addr <= '0;
          end
        end
        S_FETCH: begin
          out_data <= rd_data;
          out_idx  <= idx;
          out_last <= (idx == LAST_IDX);
        end
        S_SEND: begin
          // Address moves only on the way back into FETCH, so the bank sees one read per element.
          if (out_ready && !out_last) begin
            idx     <= idx + 1'b1;
            rd_addr <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = out_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  argmax_tracker #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .clr_first (idx == '0),
    .en        (state == S_FETCH),
    .val       (rd_data),
    .idx       (idx),
    .max_val   (max_val),
    .max_idx   (max_idx)
  );

endmodule
